uart_tx_framer: RTL and testbench

UART_TX_FRAMER -- requirements
Module: uart_tx_framer

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_tx_framer_if.sv | 11 +
 rtl/uart_baud_gen.sv | 45 ++++
 rtl/uart_tx_framer.sv | 159 +++++++++++++++
 tb/tb_uart_tx_framer.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit framer: FSM encoding and legal parameter ranges.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam int unsigned DATA_W_MIN       = 5;
  localparam int unsigned DATA_W_MAX       = 9;
  localparam int unsigned STOP_BITS_MIN    = 1;
  localparam int unsigned STOP_BITS_MAX    = 2;
  localparam int unsigned CLKS_PER_BIT_MIN = 2;

endpackage

// File: rtl/uart_tx_framer_if.sv
// Payload handshake between a producer (master) and the framer (slave).
interface uart_tx_framer_if #(
  parameter int unsigned DATA_W = 8
);
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period timer: bit_end is high in the last cycle of every CLKS_PER_BIT window.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clk1,
  input  logic rst,
  input  logic restart,
  output logic bit_end
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  if (CLKS_PER_BIT < CLKS_PER_BIT_MIN) begin : g_bad_cpb
    $error("uart_baud_gen: CLKS_PER_BIT must be >= 2");
  end

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bit_end_q, bit_end_d;

  // Count within the bit; wrap at the boundary or restart on a new frame.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (restart || (cnt_q == CNT_LAST)) begin
      cnt_d = '0;
    end
    bit_end_d = (cnt_d == CNT_LAST);
  end

  // Counter and registered boundary flag.
  always_ff @(posedge clk1 or negedge rst) begin
    if (!rst) begin
      cnt_q     <= '0;
      bit_end_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      bit_end_q <= bit_end_d;
    end
  end

  assign bit_end = bit_end_q;

endmodule

// File: rtl/uart_tx_framer.sv
// UART transmit framer: start bit, LSB-first data, optional parity, 1-2 stop bits.
module uart_tx_framer
  import uart_pkg::*;
#(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned PARITY_EN    = 0,
  parameter int unsigned PARITY_ODD   = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic              clk1,
  input  logic              rst,
  uart_tx_framer_if.slave   bus,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  localparam int unsigned IDX_W = $clog2(DATA_W + 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_W - 1);
  localparam logic             STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic             ODD_BIT   = 1'(PARITY_ODD);

  if ((DATA_W < DATA_W_MIN) || (DATA_W > DATA_W_MAX)) begin : g_bad_data_w
    $error("uart_tx_framer: DATA_W out of range 5..9");
  end
  if ((STOP_BITS < STOP_BITS_MIN) || (STOP_BITS > STOP_BITS_MAX)) begin : g_bad_stop
    $error("uart_tx_framer: STOP_BITS must be 1 or 2");
  end
  if ((PARITY_EN > 1) || (PARITY_ODD > 1)) begin : g_bad_parity
    $error("uart_tx_framer: PARITY_EN and PARITY_ODD must be 0 or 1");
  end

  uart_state_e       state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              stop_q, stop_d;
  logic              parity_q, parity_d;
  logic              tx_q, tx_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              accept_c;
  logic              bit_end;

  assign accept_c = bus.tx_valid && ready_q;

  uart_baud_gen #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk1    (clk1),
    .rst     (rst),
    .restart (accept_c),
    .bit_end (bit_end)
  );

  // Next-state and next-output logic; tx is precomputed so the line is registered.
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    idx_d    = idx_q;
    stop_d   = stop_q;
    parity_d = parity_q;
    tx_d     = tx_q;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (accept_c) begin
          state_d  = START;
          tx_d     = 1'b0;
          shift_d  = bus.tx_data;
          parity_d = (^bus.tx_data) ^ ODD_BIT;
          idx_d    = '0;
          stop_d   = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
          idx_d   = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (idx_q == IDX_LAST) begin
            if (PARITY_EN != 0) begin
              state_d = PARITY;
              tx_d    = parity_q;
            end else begin
              state_d = STOP;
              tx_d    = 1'b1;
            end
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (stop_q == STOP_LAST) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            stop_d = 1'b1;
          end
          tx_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
    ready_d = (state_d == IDLE);
    busy_d  = !ready_d;
  end

  // State and output registers; reset aborts any frame in flight.
  always_ff @(posedge clk1 or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      idx_q    <= '0;
      stop_q   <= 1'b0;
      parity_q <= 1'b0;
      tx_q     <= 1'b1;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      idx_q    <= idx_d;
      stop_q   <= stop_d;
      parity_q <= parity_d;
      tx_q     <= tx_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.tx_ready = ready_q;
  assign tx           = tx_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_uart_tx_framer.sv
// Scoreboard bench for uart_tx_framer across four parameter sets.
module tb_uart_tx_framer;

  logic       clk1 = 1'b0;
  logic       rst  = 1'b0;
  logic [8:0] tb_data  = '0;
  logic       tb_valid = 1'b0;
  int         sel   = 0;
  int         total = 0;
  int         bad   = 0;

  always #5 clk1 = ~clk1;

  // a: 8N1, b: 8E1, c: 8O1, d: 7N2 -- all 4 clocks per bit
  uart_tx_framer_if #(.DATA_W(8)) if_a ();
  uart_tx_framer_if #(.DATA_W(8)) if_b ();
  uart_tx_framer_if #(.DATA_W(8)) if_c ();
  uart_tx_framer_if #(.DATA_W(7)) if_d ();

  logic tx_a, busy_a, done_a, tx_b, busy_b, done_b;
  logic tx_c, busy_c, done_c, tx_d, busy_d, done_d;

  assign if_a.tx_data  = tb_data[7:0];
  assign if_b.tx_data  = tb_data[7:0];
  assign if_c.tx_data  = tb_data[7:0];
  assign if_d.tx_data  = tb_data[6:0];
  assign if_a.tx_valid = tb_valid && (sel == 0);
  assign if_b.tx_valid = tb_valid && (sel == 1);
  assign if_c.tx_valid = tb_valid && (sel == 2);
  assign if_d.tx_valid = tb_valid && (sel == 3);

  uart_tx_framer #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1))
    u_a (.clk1(clk1), .rst(rst), .bus(if_a.slave), .tx(tx_a), .busy(busy_a), .done(done_a));
  uart_tx_framer #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1))
    u_b (.clk1(clk1), .rst(rst), .bus(if_b.slave), .tx(tx_b), .busy(busy_b), .done(done_b));
  uart_tx_framer #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1))
    u_c (.clk1(clk1), .rst(rst), .bus(if_c.slave), .tx(tx_c), .busy(busy_c), .done(done_c));
  uart_tx_framer #(.DATA_W(7), .CLKS_PER_BIT(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2))
    u_d (.clk1(clk1), .rst(rst), .bus(if_d.slave), .tx(tx_d), .busy(busy_d), .done(done_d));

  logic mon_tx, mon_busy, mon_done, mon_ready;

  // Route the selected DUT to the monitor.
  always_comb begin
    mon_tx    = tx_a;
    mon_busy  = busy_a;
    mon_done  = done_a;
    mon_ready = if_a.tx_ready;
    case (sel)
      1: begin mon_tx = tx_b; mon_busy = busy_b; mon_done = done_b; mon_ready = if_b.tx_ready; end
      2: begin mon_tx = tx_c; mon_busy = busy_c; mon_done = done_c; mon_ready = if_c.tx_ready; end
      3: begin mon_tx = tx_d; mon_busy = busy_d; mon_done = done_d; mon_ready = if_d.tx_ready; end
      default: ;
    endcase
  end

  // Expected frame: line levels per bit period in transmit order ("0" = start bit first).
  typedef struct {
    string name;
    string bits;
    int    abort_cyc;
    bit    b2b;
  } exp_t;

  exp_t exp_q[$];
  bit   mon_active = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, expv);
    end
  endtask

  task automatic push(input string name, input string bits, input int abort_cyc, input bit b2b);
    exp_t e;
    e.name = name; e.bits = bits; e.abort_cyc = abort_cyc; e.b2b = b2b;
    exp_q.push_back(e);
  endtask

  // Monitor: waits for a start bit, checks every cycle of the frame and the done cycle.
  initial begin
    forever begin
      exp_t e;
      int   w;
      int   len;
      @(negedge clk1);
      if (exp_q.size() == 0) continue;
      e = exp_q.pop_front();
      mon_active = 1'b1;
      len = e.bits.len();
      w = 0;
      if (!e.b2b) begin
        while (mon_tx !== 1'b0 && w < 300) begin
          @(negedge clk1);
          w++;
        end
      end
      if (w >= 300) begin
        chk({e.name, " start_timeout"}, 32'd0, 32'd1);
      end else begin
        for (int c = 0; c <= len * 4; c++) begin
          if (c > 0) @(negedge clk1);
          if (e.abort_cyc >= 0 && c == e.abort_cyc) begin
            chk($sformatf("%s rst_tx c%0d", e.name, c), 32'(mon_tx), 32'd1);
            chk($sformatf("%s rst_ready c%0d", e.name, c), 32'(mon_ready), 32'd1);
            chk($sformatf("%s rst_busy c%0d", e.name, c), 32'(mon_busy), 32'd0);
            chk($sformatf("%s rst_done c%0d", e.name, c), 32'(mon_done), 32'd0);
            for (int k = 0; k < 3; k++) begin
              @(negedge clk1);
              chk($sformatf("%s rst_nodone k%0d", e.name, k), 32'(mon_done), 32'd0);
            end
            break;
          end
          if (c < len * 4) begin
            chk($sformatf("%s tx c%0d", e.name, c), 32'(mon_tx), 32'(e.bits[c/4] == "1"));
            chk($sformatf("%s ready c%0d", e.name, c), 32'(mon_ready), 32'd0);
            chk($sformatf("%s busy c%0d", e.name, c), 32'(mon_busy), 32'd1);
            chk($sformatf("%s done c%0d", e.name, c), 32'(mon_done), 32'd0);
          end else begin
            chk($sformatf("%s done_end c%0d", e.name, c), 32'(mon_done), 32'd1);
            chk($sformatf("%s ready_end", e.name), 32'(mon_ready), 32'd1);
            chk($sformatf("%s busy_end", e.name), 32'(mon_busy), 32'd0);
            chk($sformatf("%s tx_end", e.name), 32'(mon_tx), 32'd1);
          end
        end
      end
      mon_active = 1'b0;
    end
  end

  // Offer one payload and drop valid right after the accepting edge.
  task automatic send(input int s, input logic [8:0] d);
    int w = 0;
    sel = s;
    @(negedge clk1);
    tb_data  = d;
    tb_valid = 1'b1;
    while (!mon_ready && w < 100) begin
      @(negedge clk1);
      w++;
    end
    if (w >= 100) chk("send_ready_timeout", 32'd0, 32'd1);
    @(posedge clk1);
    #1 tb_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int w = 0;
    while ((exp_q.size() != 0 || mon_active) && w < 500) begin
      @(negedge clk1);
      w++;
    end
    if (w >= 500) chk("idle_timeout", 32'd0, 32'd1);
    repeat (2) @(negedge clk1);
  endtask

  initial begin
    // Reset state of every configuration.
    repeat (3) @(posedge clk1);
    for (int s = 0; s < 4; s++) begin
      sel = s;
      #1;
      chk($sformatf("reset_tx dut%0d", s), 32'(mon_tx), 32'd1);
      chk($sformatf("reset_ready dut%0d", s), 32'(mon_ready), 32'd1);
      chk($sformatf("reset_busy dut%0d", s), 32'(mon_busy), 32'd0);
      chk($sformatf("reset_done dut%0d", s), 32'(mon_done), 32'd0);
    end
    @(posedge clk1);
    #2 rst = 1'b1;

    // 8N1 0xA5
    push("a5", "0101001011", -1, 1'b0);
    send(0, 9'h0A5);
    wait_idle();

    // 8E1 / 8O1 0x07: parity 1 for even, 0 for odd
    push("par_even", "01110000011", -1, 1'b0);
    send(1, 9'h007);
    wait_idle();
    push("par_odd", "01110000001", -1, 1'b0);
    send(2, 9'h007);
    wait_idle();

    // 7N2 0x55
    push("w7s2", "0101010111", -1, 1'b0);
    send(3, 9'h055);
    wait_idle();

    // Back-to-back 0x3C then 0xC3 with valid held high
    push("b2b_3c", "0001111001", -1, 1'b0);
    push("b2b_c3", "0110000111", -1, 1'b1);
    begin
      int w = 0;
      sel = 0;
      @(negedge clk1);
      tb_data  = 9'h03C;
      tb_valid = 1'b1;
      while (!mon_ready && w < 100) begin @(negedge clk1); w++; end
      @(posedge clk1);
      #1 tb_data = 9'h0C3;
      @(negedge clk1);
      w = 0;
      while (!mon_ready && w < 100) begin @(negedge clk1); w++; end
      if (w >= 100) chk("b2b_ready_timeout", 32'd0, 32'd1);
      @(posedge clk1);
      #1 tb_valid = 1'b0;
    end
    wait_idle();

    // Payload and valid changes while busy are ignored
    push("busy_a5", "0101001011", -1, 1'b0);
    send(0, 9'h0A5);
    repeat (20) @(posedge clk1);
    #1 tb_data = 9'h0FF;
    tb_valid = 1'b1;
    @(posedge clk1);
    #1 tb_valid = 1'b0;
    wait_idle();

    // Reset during frame bit 3 aborts without done; next frame is clean
    push("rst_abort", "0101001011", 13, 1'b0);
    send(0, 9'h0A5);
    repeat (13) @(posedge clk1);
    #2 rst = 1'b0;
    repeat (5) @(posedge clk1);
    #2 rst = 1'b1;
    wait_idle();
    push("after_rst_81", "0100000011", -1, 1'b0);
    send(0, 9'h081);
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
